// File: rtl/aes_block_fetch_pkg.sv
// aes_block_fetch_pkg: shared widths and FSM state encodings for the AES
// block fetch sequencer. Optional build macro: AES_FETCH_BSWAP_EN.
`ifndef AES_BLOCK_FETCH_DEFINES
`define AES_BLOCK_FETCH_DEFINES

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef BLOCK_WIDTH
`define BLOCK_WIDTH 128
`endif
`ifndef WORDS_PER_BLOCK
`define WORDS_PER_BLOCK (`BLOCK_WIDTH / `WORD_WIDTH)
`endif

`define AES_ST_IDLE  3'd0
`define AES_ST_FETCH 3'd1
`define AES_ST_DRAIN 3'd2
`define AES_ST_HOLD  3'd3
`define AES_ST_FIN   3'd4

`endif

package aes_block_fetch_pkg;

    localparam int FETCH_PIPE_DEPTH = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = `AES_ST_IDLE,
        ST_FETCH = `AES_ST_FETCH,
        ST_DRAIN = `AES_ST_DRAIN,
        ST_HOLD  = `AES_ST_HOLD,
        ST_FIN   = `AES_ST_FIN
    } state_t;

endpackage

// File: rtl/aes_word_packer.sv
// aes_word_packer: shifts memory words into a 128-bit block, word 0 ending in
// the MSBs. Optional build macro AES_FETCH_BSWAP_EN byte-reverses each word
// before insertion (little-endian memory image).
module aes_word_packer
    import aes_block_fetch_pkg::*;
#(
    parameter int WORD_WIDTH  = `WORD_WIDTH,
    parameter int BLOCK_WIDTH = `BLOCK_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   i_cap,
    input  logic                   i_clear,
    input  logic [WORD_WIDTH-1:0]  i_word,
    output logic [BLOCK_WIDTH-1:0] o_block,
    output logic                   o_last,
    output logic                   o_full
);

    localparam int WPB = BLOCK_WIDTH / WORD_WIDTH;
    localparam int CW  = (WPB > 1) ? $clog2(WPB) : 1;
    localparam logic [CW-1:0] LAST_CAP = CW'(WPB - 1);

    logic [BLOCK_WIDTH-1:0] r_block;
    logic [CW-1:0]          r_cap_cnt;
    logic                   r_full;
    logic [WORD_WIDTH-1:0]  w_word;

`ifdef AES_FETCH_BSWAP_EN
    function automatic logic [WORD_WIDTH-1:0] byte_swap(input logic [WORD_WIDTH-1:0] w);
        logic [WORD_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WORD_WIDTH / 8; i++) begin
            r[8*i +: 8] = w[WORD_WIDTH-8-8*i +: 8];
        end
        return r;
    endfunction

    assign w_word = byte_swap(i_word);
`else
    assign w_word = i_word;
`endif

    // The capture that completes a block; the FSM leaves DRAIN on this.
    assign o_last  = i_cap && (r_cap_cnt == LAST_CAP);
    assign o_block = r_block;
    assign o_full  = r_full;

    // Shift-in register, capture counter and full flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_block   <= '0;
            r_cap_cnt <= '0;
            r_full    <= 1'b0;
        end else begin
            if (i_cap) begin
                r_block   <= {r_block[BLOCK_WIDTH-WORD_WIDTH-1:0], w_word};
                r_cap_cnt <= o_last ? '0 : r_cap_cnt + 1'b1;
            end
            if (o_last) begin
                r_full <= 1'b1;
            end else if (i_clear) begin
                r_full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/aes_block_fetch.sv
// aes_block_fetch: drives the address counter enable, follows each issue
// through a 2-deep valid pipe (counter update + synchronous memory read) and
// hands packed 128-bit blocks to the AES core over valid/ready, for a burst of
// num_blocks_i blocks. Optional build macro AES_FETCH_BSWAP_EN (see packer).
module aes_block_fetch
    import aes_block_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = `ADDR_WIDTH,
    parameter int WORD_WIDTH  = `WORD_WIDTH,
    parameter int BLOCK_WIDTH = `BLOCK_WIDTH,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [CNT_WIDTH-1:0]   num_blocks_i,
    input  logic [ADDR_WIDTH-1:0]  pc_i,
    output logic                   pc_en_o,
    input  logic [WORD_WIDTH-1:0]  mem_rdata_i,
    output logic [BLOCK_WIDTH-1:0] block_o,
    output logic                   block_valid_o,
    input  logic                   block_ready_i,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int WPB = BLOCK_WIDTH / WORD_WIDTH;
    localparam int IW  = (WPB > 1) ? $clog2(WPB) : 1;
    localparam logic [IW-1:0] LAST_ISSUE = IW'(WPB - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IW-1:0]          r_issue_cnt;
    logic                   r_vld_p1;
    logic                   r_vld_p2;
    logic [CNT_WIDTH-1:0]   r_remaining;
    logic                   w_last_issue;
    logic                   w_last_cap;
    logic                   w_full;
    logic                   w_hs;
    logic                   w_unused_pc;

    // The address reaches the memory externally; it is not needed here.
    assign w_unused_pc  = ^pc_i;

    assign w_last_issue = pc_en_o && (r_issue_cnt == LAST_ISSUE);
    assign w_hs         = block_valid_o && block_ready_i;

    aes_word_packer #(
        .WORD_WIDTH  (WORD_WIDTH),
        .BLOCK_WIDTH (BLOCK_WIDTH)
    ) u_packer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_cap   (r_vld_p2),
        .i_clear (w_hs),
        .i_word  (mem_rdata_i),
        .o_block (block_o),
        .o_last  (w_last_cap),
        .o_full  (w_full)
    );

    // State register, issue counter, valid pipe and remaining-block counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_issue_cnt <= '0;
            r_vld_p1    <= 1'b0;
            r_vld_p2    <= 1'b0;
            r_remaining <= '0;
        end else begin
            r_state <= w_state_nxt;
            // issue -> counter update (p1) -> memory read data (p2)
            r_vld_p1 <= pc_en_o;
            r_vld_p2 <= r_vld_p1;
            if (pc_en_o) begin
                r_issue_cnt <= w_last_issue ? '0 : r_issue_cnt + 1'b1;
            end
            if ((r_state == ST_IDLE) && start_i) begin
                r_remaining <= num_blocks_i;
            end else if (w_hs) begin
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

    // Next-state and Moore outputs.
    always_comb begin
        w_state_nxt   = r_state;
        pc_en_o       = 1'b0;
        block_valid_o = 1'b0;
        busy_o        = 1'b1;
        done_o        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    w_state_nxt = (num_blocks_i == '0) ? ST_FIN : ST_FETCH;
                end
            end
            ST_FETCH: begin
                pc_en_o = 1'b1;
                if (w_last_issue) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_last_cap) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                block_valid_o = w_full;
                if (w_full && block_ready_i) begin
                    w_state_nxt = (r_remaining == CNT_WIDTH'(1)) ? ST_FIN : ST_FETCH;
                end
            end
            ST_FIN: begin
                done_o      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_block_fetch.sv
// tb_aes_block_fetch: directed bench with a counter/memory model and a block
// scoreboard for aes_block_fetch. Honours AES_FETCH_BSWAP_EN when defined.
module tb_aes_block_fetch;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   nblk;
    logic [7:0]   pc;
    logic         pc_en;
    logic [31:0]  rdata;
    logic [127:0] block;
    logic         valid;
    logic         ready;
    logic         busy;
    logic         done;

    logic         pc_rst;
    logic         pc_ld;
    logic [7:0]   pc_ld_val;
    logic [31:0]  mem [256];

    int applied = 0;
    int miscompares = 0;
    int pc_en_cnt = 0;
    int done_cnt = 0;
    int blk_cnt = 0;
    logic [127:0] exp_q [$];
    logic [127:0] prev_blk = '0;
    logic         prev_stall = 1'b0;

    always #5 clk = ~clk;

    aes_block_fetch dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .num_blocks_i  (nblk),
        .pc_i          (pc),
        .pc_en_o       (pc_en),
        .mem_rdata_i   (rdata),
        .block_o       (block),
        .block_valid_o (valid),
        .block_ready_i (ready),
        .busy_o        (busy),
        .done_o        (done)
    );

    // Address counter: resets to all-ones, pre-incremented on enable.
    always_ff @(posedge clk) begin
        if (pc_rst)     pc <= 8'hFF;
        else if (pc_ld) pc <= pc_ld_val;
        else if (pc_en) pc <= pc + 8'd1;
    end

    // Synchronous-read memory.
    always_ff @(posedge clk) rdata <= mem[pc];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        applied++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef AES_FETCH_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [127:0] exp_block(input logic [7:0] base);
        logic [7:0] a0, a1, a2, a3;
        a0 = base; a1 = base + 8'd1; a2 = base + 8'd2; a3 = base + 8'd3;
        return {exp_word(mem[a0]), exp_word(mem[a1]), exp_word(mem[a2]), exp_word(mem[a3])};
    endfunction

    task automatic push_blocks(input int n);
        logic [7:0] base;
        base = pc + 8'd1;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(exp_block(base));
            base = base + 8'd4;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!valid && n < 50) begin
            tick(1);
            n++;
        end
        chk(tag, {127'd0, valid}, 128'd1);
    endtask

    task automatic handshake();
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
    endtask

    // Monitor: counts enables/done pulses, scoreboards blocks at handshake,
    // and checks block stability while stalled.
    always @(negedge clk) begin
        if (pc_en) pc_en_cnt++;
        if (done)  done_cnt++;
        if (valid) begin
            if (prev_stall) chk("hold_stable", block, prev_blk);
            if (ready) begin
                if (exp_q.size() == 0) chk("unexpected_block", {127'd0, valid}, 128'd0);
                else                   chk("block", block, exp_q.pop_front());
                blk_cnt++;
            end
        end
        prev_stall = valid && !ready && !rst;
        prev_blk   = block;
    end

    logic [11:0] en_tr, vld_tr, done_tr, busy_tr;
    int en0, dn0, bk0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'(i + 1);
        rst = 1'b1; pc_rst = 1'b1; pc_ld = 1'b0; pc_ld_val = '0;
        start = 1'b0; nblk = '0; ready = 1'b0;
        tick(2);
        @(negedge clk);
        chk("reset_block", block, 128'd0);
        chk("reset_ctrl", {124'd0, pc_en, valid, busy, done}, 128'd0);
        @(posedge clk); #1;
        rst = 1'b0; pc_rst = 1'b0;
        tick(1);

        // Single block, ready held high, cycle-accurate trace.
        ready = 1'b1; nblk = 8'd1; start = 1'b1;
        push_blocks(1);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            en_tr[c] = pc_en; vld_tr[c] = valid; done_tr[c] = done; busy_tr[c] = busy;
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("t1_pc_en_cycles", {116'd0, en_tr}, 128'h01E);
        chk("t1_valid_cycle", {116'd0, vld_tr}, 128'h080);
        chk("t1_done_cycle", {116'd0, done_tr}, 128'h100);
        chk("t1_busy_cycles", {116'd0, busy_tr}, 128'h1FE);
        chk("t1_blocks_seen", 128'(blk_cnt), 128'd1);
        ready = 1'b0;

        // Three blocks with a 5-cycle stall on each.
        en0 = pc_en_cnt; dn0 = done_cnt; bk0 = blk_cnt;
        nblk = 8'd3; start = 1'b1;
        push_blocks(3);
        tick(1);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_valid("t2_valid_timeout");
            tick(5);
            chk("t2_valid_while_stalled", {127'd0, valid}, 128'd1);
            handshake();
        end
        tick(3);
        chk("t2_pc_en_count", 128'(pc_en_cnt - en0), 128'd12);
        chk("t2_done_count", 128'(done_cnt - dn0), 128'd1);
        chk("t2_block_count", 128'(blk_cnt - bk0), 128'd3);
        chk("t2_busy_after", {127'd0, busy}, 128'd0);

        // Zero-length burst.
        en0 = pc_en_cnt;
        nblk = 8'd0; start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            en_tr[c] = pc_en; vld_tr[c] = valid; done_tr[c] = done;
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("t3_done_cycle", {124'd0, done_tr[3:0]}, 128'h2);
        chk("t3_no_pc_en", {124'd0, en_tr[3:0]}, 128'h0);
        chk("t3_no_valid", {124'd0, vld_tr[3:0]}, 128'h0);

        // Counter near its top: addresses FE, FF, 00, 01.
        pc_ld = 1'b1; pc_ld_val = 8'hFD;
        tick(1);
        pc_ld = 1'b0;
        tick(1);
        ready = 1'b1; nblk = 8'd1; start = 1'b1;
`ifdef AES_FETCH_BSWAP_EN
        exp_q.push_back({32'hFF000000, 32'h00010000, 32'h01000000, 32'h02000000});
`else
        exp_q.push_back(128'h000000FF_00000100_00000001_00000002);
`endif
        tick(1);
        start = 1'b0;
        wait_valid("t4_valid_timeout");
        tick(3);
        ready = 1'b0;
        chk("t4_pc_after_wrap", {120'd0, pc}, 128'h01);

        // Reset in cycle 5 of a burst.
        ready = 1'b1; nblk = 8'd2; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_block_after_rst", block, 128'd0);
        chk("t5_ctrl_after_rst", {124'd0, pc_en, valid, busy, done}, 128'd0);
        chk("t5_pc_kept", {120'd0, pc}, 128'h05);
        @(posedge clk); #1;
        nblk = 8'd1; start = 1'b1;
        push_blocks(1);
        tick(1);
        start = 1'b0;
        wait_valid("t5_valid_timeout");
        tick(3);
        ready = 1'b0;

        // Reset and start together: reset wins.
        en0 = pc_en_cnt;
        rst = 1'b1; start = 1'b1; nblk = 8'd1;
        tick(1);
        rst = 1'b0; start = 1'b0;
        tick(3);
        chk("t6_rst_start_busy", {127'd0, busy}, 128'd0);
        chk("t6_rst_start_no_en", 128'(pc_en_cnt - en0), 128'd0);

        // Byte order of a distinctive word; start during HOLD is ignored.
        mem[pc + 8'd1] = 32'h11223344;
        en0 = pc_en_cnt; dn0 = done_cnt;
        nblk = 8'd1; start = 1'b1;
        push_blocks(1);
        tick(1);
        start = 1'b0;
        wait_valid("t7_valid_timeout");
`ifdef AES_FETCH_BSWAP_EN
        chk("t7_word0_order", {96'd0, block[127:96]}, 128'h44332211);
`else
        chk("t7_word0_order", {96'd0, block[127:96]}, 128'h11223344);
`endif
        nblk = 8'd5; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        chk("t7_still_holding", {127'd0, valid}, 128'd1);
        handshake();
        tick(6);
        chk("t7_pc_en_count", 128'(pc_en_cnt - en0), 128'd4);
        chk("t7_done_count", 128'(done_cnt - dn0), 128'd1);
        chk("t7_idle_after", {126'd0, busy, valid}, 128'd0);
        chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
